// File: rtl/sram_ctrl_pkg.sv
// Shared types and derived-size helpers for the SRAM burst controller.
// Beat counts and counter widths are computed from the module parameters.
package sram_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

  function automatic int bpw(input int data_w, input int dq_w);
    return data_w / dq_w;
  endfunction

  function automatic int rd_beats(input int data_w, input int dq_w, input int burst_words);
    return burst_words * (data_w / dq_w);
  endfunction

  function automatic int wr_beats(input int data_w, input int dq_w);
    return data_w / dq_w;
  endfunction

  // Width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic bit params_legal(input int data_w, input int dq_w,
                                      input int burst_words, input int wait_cycles);
    return (dq_w == 8 || dq_w == 16) && (data_w % dq_w == 0) && (data_w >= dq_w) &&
           (burst_words >= 1) && (burst_words <= 8) &&
           (wait_cycles >= 0) && (wait_cycles <= 7);
  endfunction

endpackage

// File: rtl/sram_beat_timer.sv
// Wait-state and beat counters for one SRAM access; the wait counter
// runs 0..WAIT_CYCLES and the beat index steps on the last cycle of each beat.
module sram_beat_timer
  import sram_ctrl_pkg::*;
#(
  parameter int WAIT_CYCLES = 1,
  parameter int MAX_BEATS   = 4,
  localparam int BEAT_W     = cnt_w(MAX_BEATS),
  localparam int WAIT_W     = cnt_w(WAIT_CYCLES + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              en,
  input  logic [BEAT_W-1:0] last_idx,
  output logic [BEAT_W-1:0] beat,
  output logic              last_cycle,
  output logic              last_beat
);

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_CYCLES);

  logic [WAIT_W-1:0] wait_cnt;

  assign last_cycle = (wait_cnt == WAIT_LAST);
  assign last_beat  = (beat == last_idx);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
      beat     <= '0;
    end else if (clear) begin
      wait_cnt <= '0;
      beat     <= '0;
    end else if (en) begin
      if (last_cycle) begin
        wait_cnt <= '0;
        if (!last_beat) beat <= beat + 1'b1;
      end else begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sram_burst_controller.sv
// Bridges a stalled pipeline stage to an asynchronous SRAM: burst reads,
// serialised single-word writes, programmable wait states, registered strobes.
module sram_burst_controller
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int DQ_W        = 16,
  parameter int SRAM_ADDR_W = 18,
  parameter int BURST_WORDS = 2,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rd_en,
  input  logic                          wr_en,
  input  logic [ADDR_W-1:0]             address,
  input  logic [DATA_W-1:0]             write_data,
  output logic [BURST_WORDS*DATA_W-1:0] read_data,
  output logic                          ready,
  inout  wire  [DQ_W-1:0]               SRAM_DQ,
  output logic [SRAM_ADDR_W-1:0]        SRAM_ADDR,
  output logic                          SRAM_WE_N,
  output logic                          SRAM_OE_N,
  output logic                          SRAM_CE_N
);

  localparam int BPW        = bpw(DATA_W, DQ_W);
  localparam int RD_BEATS   = rd_beats(DATA_W, DQ_W, BURST_WORDS);
  localparam int WR_BEATS   = wr_beats(DATA_W, DQ_W);
  localparam int BEAT_W     = cnt_w(RD_BEATS);
  localparam int BYTE_SHIFT = $clog2(DQ_W / 8);
  localparam int RD_W       = BURST_WORDS * DATA_W;

  generate
    if (!params_legal(DATA_W, DQ_W, BURST_WORDS, WAIT_CYCLES)) begin : g_bad_params
      $error("sram_burst_controller: illegal parameter combination");
    end
  endgenerate

  state_t               state, state_nxt;
  op_t                  op;
  logic [SRAM_ADDR_W-1:0] base;
  logic [DATA_W-1:0]    wdata;
  logic                 accept;

  logic [BEAT_W-1:0]    beat;
  logic [BEAT_W-1:0]    last_idx;
  logic                 last_cycle;
  logic                 last_beat;

  logic                 acc_rd, acc_wr;
  logic [DQ_W-1:0]      dq_nxt;
  logic [DQ_W-1:0]      dq_out;
  logic                 dq_oe;

  logic                 smp_en;
  logic                 smp_last;
  logic [BEAT_W-1:0]    smp_beat;
  logic [RD_W-1:0]      rd_buf, rd_buf_nxt;

  assign accept   = (state == IDLE) && (rd_en || wr_en);
  assign acc_rd   = (state == ACCESS) && (op == OP_RD);
  assign acc_wr   = (state == ACCESS) && (op == OP_WR);
  assign last_idx = (op == OP_RD) ? BEAT_W'(RD_BEATS - 1) : BEAT_W'(WR_BEATS - 1);

  sram_beat_timer #(
    .WAIT_CYCLES (WAIT_CYCLES),
    .MAX_BEATS   (RD_BEATS)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .clear      (accept),
    .en         (state == ACCESS),
    .last_idx   (last_idx),
    .beat       (beat),
    .last_cycle (last_cycle),
    .last_beat  (last_beat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (rd_en || wr_en) state_nxt = ACCESS;
      ACCESS:  if (last_cycle && last_beat) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Read wins a tie; a still-held write is picked up on the next IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op    <= OP_RD;
      base  <= '0;
      wdata <= '0;
    end else if (accept) begin
      op    <= rd_en ? OP_RD : OP_WR;
      base  <= SRAM_ADDR_W'(address >> BYTE_SHIFT);
      wdata <= write_data;
    end
  end

  assign dq_nxt = DQ_W'(wdata >> (DQ_W * int'(beat)));

  // Pins are one register stage behind the state/timer; smp_* track what
  // the pins are showing so the read sample lines up with the strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      SRAM_CE_N <= 1'b1;
      SRAM_OE_N <= 1'b1;
      SRAM_WE_N <= 1'b1;
      SRAM_ADDR <= '0;
      dq_oe     <= 1'b0;
      dq_out    <= '0;
      ready     <= 1'b0;
      smp_en    <= 1'b0;
      smp_last  <= 1'b0;
      smp_beat  <= '0;
    end else begin
      SRAM_CE_N <= !(state == ACCESS);
      SRAM_OE_N <= !acc_rd;
      SRAM_WE_N <= !(acc_wr && (!last_cycle || (WAIT_CYCLES == 0)));
      if (state == ACCESS) SRAM_ADDR <= base + SRAM_ADDR_W'(beat);
      dq_oe     <= acc_wr;
      dq_out    <= dq_nxt;
      ready     <= (state == DONE);
      smp_en    <= acc_rd && last_cycle;
      smp_last  <= last_beat;
      smp_beat  <= beat;
    end
  end

  assign SRAM_DQ = dq_oe ? dq_out : {DQ_W{1'bz}};

  always_comb begin
    rd_buf_nxt = rd_buf;
    rd_buf_nxt[int'(smp_beat)*DQ_W +: DQ_W] = SRAM_DQ;
  end

  // read_data only changes when the final beat lands, so it stays stable
  // across writes and partial reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_buf    <= '0;
      read_data <= '0;
    end else if (smp_en) begin
      rd_buf <= rd_buf_nxt;
      if (smp_last) read_data <= rd_buf_nxt;
    end
  end

endmodule

// File: tb/tb_sram_burst_controller.sv
// Self-checking bench: behavioural SRAM plus an arithmetic reference model
// of burst reads, serialised writes, latency and address wrap.
module tb_sram_burst_controller;

  localparam int DQ_W  = 16;
  localparam int SA_W  = 18;
  localparam int WC    = 1;
  localparam int BPW   = 32 / DQ_W;
  localparam int RD_N  = 2 * BPW;
  localparam int WR_N  = BPW;
  localparam int MEM_N = 1 << SA_W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        rd_en, wr_en, ready;
  logic [31:0] address, write_data;
  logic [63:0] read_data;
  wire  [15:0] sram_dq;
  logic [17:0] sram_addr;
  logic        we_n, oe_n, ce_n;

  logic        n_rd, n_wr, n_ready;
  logic [31:0] n_addr, n_wdata, n_read_data;
  wire  [7:0]  n_dq;
  logic [17:0] n_sa;
  logic        n_we, n_oe, n_ce;

  sram_burst_controller dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .address(address),
    .write_data(write_data), .read_data(read_data), .ready(ready),
    .SRAM_DQ(sram_dq), .SRAM_ADDR(sram_addr), .SRAM_WE_N(we_n),
    .SRAM_OE_N(oe_n), .SRAM_CE_N(ce_n)
  );

  sram_burst_controller #(
    .ADDR_W(32), .DATA_W(32), .DQ_W(8), .SRAM_ADDR_W(18),
    .BURST_WORDS(1), .WAIT_CYCLES(0)
  ) dut_n (
    .clk(clk), .rst(rst), .rd_en(n_rd), .wr_en(n_wr), .address(n_addr),
    .write_data(n_wdata), .read_data(n_read_data), .ready(n_ready),
    .SRAM_DQ(n_dq), .SRAM_ADDR(n_sa), .SRAM_WE_N(n_we),
    .SRAM_OE_N(n_oe), .SRAM_CE_N(n_ce)
  );

  // Behavioural SRAMs (what the pins touch) and the reference image.
  logic [15:0] mem     [MEM_N];
  logic [15:0] ref_mem [MEM_N];
  logic [7:0]  mem8    [MEM_N];
  logic [33:0] wr_log[$];
  logic [17:0] addr_seen[$];

  assign sram_dq = (!ce_n && !oe_n && we_n) ? mem[sram_addr] : 16'hzzzz;
  assign n_dq    = (!n_ce && !n_oe && n_we) ? mem8[n_sa] : 8'hzz;

  always @(negedge clk) begin
    if (!ce_n && !we_n) begin
      mem[sram_addr] = sram_dq;
      wr_log.push_back({sram_addr, sram_dq});
    end
  end

  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] exp_rd = 64'h0;

  function automatic int base_of(input logic [31:0] a);
    return int'((a >> 1) % MEM_N);
  endfunction

  function automatic logic [63:0] ref_read(input logic [31:0] a);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < RD_N; i++) r[i*16 +: 16] = ref_mem[(base_of(a) + i) % MEM_N];
    return r;
  endfunction

  function automatic int exp_lat(input int beats, input int wc);
    return 1 + beats * (wc + 1);
  endfunction

  task automatic run_req(input bit rd, input bit wr, input logic [31:0] a,
                         input logic [31:0] d, output int lat, output int oe_cnt,
                         output int we_cnt, output bit drv_bad);
    @(negedge clk);
    rd_en = rd; wr_en = wr; address = a; write_data = d;
    wr_log.delete(); addr_seen.delete();
    oe_cnt = 0; we_cnt = 0; drv_bad = 1'b0;
    @(posedge clk);
    lat = 0;
    while (lat < 40) begin
      @(posedge clk); #1;
      lat++;
      address = $urandom; write_data = $urandom;
      if (!oe_n) oe_cnt++;
      if (!we_n) we_cnt++;
      if (rd && dut.dq_oe) drv_bad = 1'b1;
      if (!ce_n && (addr_seen.size() == 0 || addr_seen[$] != sram_addr))
        addr_seen.push_back(sram_addr);
      if (ready) break;
    end
    rd_en = 1'b0; wr_en = 1'b0;
  endtask

  task automatic check_write(input string tag, input logic [31:0] a, input logic [31:0] d,
                             input int lat, input int oe_cnt, input int we_cnt);
    logic [33:0] e;
    n_vec++;
    if (lat !== exp_lat(WR_N, WC)) begin
      n_err++; $display("FAIL %s latency: got %0d need %0d", tag, lat, exp_lat(WR_N, WC));
    end
    n_vec++;
    if (wr_log.size() !== WR_N || we_cnt !== WR_N || oe_cnt !== 0) begin
      n_err++;
      $display("FAIL %s strobes: log %0d we %0d oe %0d need %0d/%0d/0",
               tag, wr_log.size(), we_cnt, oe_cnt, WR_N, WR_N);
    end
    for (int i = 0; i < WR_N; i++) begin
      e = {18'((base_of(a) + i) % MEM_N), d[i*16 +: 16]};
      n_vec++;
      if (i >= wr_log.size() || wr_log[i] !== e) begin
        n_err++;
        $display("FAIL %s beat%0d: got %h need %h", tag, i,
                 (i < wr_log.size()) ? wr_log[i] : 34'h0, e);
      end
      ref_mem[(base_of(a) + i) % MEM_N] = d[i*16 +: 16];
    end
    n_vec++;
    if (read_data !== exp_rd) begin
      n_err++; $display("FAIL %s read_data disturbed: got %h need %h", tag, read_data, exp_rd);
    end
  endtask

  task automatic check_read(input string tag, input logic [31:0] a, input int lat,
                            input int oe_cnt, input bit drv_bad);
    exp_rd = ref_read(a);
    n_vec++;
    if (read_data !== exp_rd) begin
      n_err++; $display("FAIL %s data: got %h need %h", tag, read_data, exp_rd);
    end
    n_vec++;
    if (lat !== exp_lat(RD_N, WC)) begin
      n_err++; $display("FAIL %s latency: got %0d need %0d", tag, lat, exp_lat(RD_N, WC));
    end
    n_vec++;
    if (oe_cnt !== RD_N * (WC + 1) || drv_bad !== 1'b0) begin
      n_err++; $display("FAIL %s oe/drive: oe %0d drv %0d need %0d/0", tag, oe_cnt, drv_bad,
                        RD_N * (WC + 1));
    end
    for (int i = 0; i < RD_N; i++) begin
      n_vec++;
      if (i >= addr_seen.size() || addr_seen[i] !== 18'((base_of(a) + i) % MEM_N)) begin
        n_err++;
        $display("FAIL %s addr%0d: got %h need %h", tag, i,
                 (i < addr_seen.size()) ? addr_seen[i] : 18'h0, 18'((base_of(a) + i) % MEM_N));
      end
    end
  endtask

  task automatic test_reset();
    n_vec++;
    if (ready !== 1'b0 || read_data !== 64'h0 || sram_addr !== 18'h0) begin
      n_err++; $display("FAIL reset regs: ready %b rd %h addr %h need 0", ready, read_data, sram_addr);
    end
    n_vec++;
    if ({we_n, oe_n, ce_n} !== 3'b111) begin
      n_err++; $display("FAIL reset strobes: got %b need 111", {we_n, oe_n, ce_n});
    end
    n_vec++;
    if (dut.dq_oe !== 1'b0) begin
      n_err++; $display("FAIL reset dq drive: got %b need 0", dut.dq_oe);
    end
  endtask

  task automatic test_write_directed();
    int lat, oe, we; bit drv;
    run_req(1'b0, 1'b1, 32'h404, 32'hDEADBEEF, lat, oe, we, drv);
    check_write("wr_dir", 32'h404, 32'hDEADBEEF, lat, oe, we);
  endtask

  task automatic test_read_directed();
    int lat, oe, we; bit drv;
    mem[18'h204] = 16'h1234; ref_mem[18'h204] = 16'h1234;
    mem[18'h205] = 16'h5678; ref_mem[18'h205] = 16'h5678;
    run_req(1'b1, 1'b0, 32'h404, 32'h0, lat, oe, we, drv);
    check_read("rd_dir", 32'h404, lat, oe, drv);
    n_vec++;
    if (read_data !== 64'h56781234DEADBEEF) begin
      n_err++; $display("FAIL rd_dir literal: got %h need 56781234deadbeef", read_data);
    end
  endtask

  task automatic test_wrap();
    int lat, oe, we; bit drv;
    logic [17:0] wa [4];
    wa[0] = 18'h3FFFE; wa[1] = 18'h3FFFF; wa[2] = 18'h0; wa[3] = 18'h1;
    for (int i = 0; i < 4; i++) begin
      mem[wa[i]] = 16'($urandom); ref_mem[wa[i]] = mem[wa[i]];
    end
    run_req(1'b1, 1'b0, 32'h7FFFC, 32'h0, lat, oe, we, drv);
    check_read("wrap", 32'h7FFFC, lat, oe, drv);
  endtask

  task automatic test_random();
    int lat, oe, we; bit drv, rd;
    logic [31:0] a, d;
    for (int n = 0; n < 30; n++) begin
      rd = 1'($urandom_range(0, 1));
      a  = ($urandom & 32'hFFF8_0000) |
           (($urandom_range(0, 1) == 1) ? 32'h7FFC0 : 32'h00400) |
           (32'($urandom_range(0, 31)) << 1) | 32'($urandom_range(0, 1));
      d  = $urandom;
      run_req(rd, !rd, a, d, lat, oe, we, drv);
      if (rd) check_read("rand_rd", a, lat, oe, drv);
      else    check_write("rand_wr", a, d, lat, oe, we);
    end
  endtask

  task automatic test_back_to_back();
    int pulses, lat1, lat2, cyc;
    logic [31:0] a, d;
    logic [63:0] rd_exp;
    logic [33:0] e;
    a = 32'h0000_0A00 | (32'($urandom_range(0, 15)) << 1);
    d = $urandom;
    rd_exp = ref_read(a);
    @(negedge clk);
    rd_en = 1'b1; wr_en = 1'b1; address = a; write_data = d; wr_log.delete();
    @(posedge clk);
    pulses = 0; lat1 = -1; lat2 = -1;
    for (cyc = 1; cyc <= 40; cyc++) begin
      @(posedge clk); #1;
      if (ready) begin
        pulses++;
        if (pulses == 1) begin
          lat1 = cyc; rd_en = 1'b0;
          n_vec++;
          if (read_data !== rd_exp) begin
            n_err++; $display("FAIL b2b read data: got %h need %h", read_data, rd_exp);
          end
        end else if (pulses == 2) begin
          lat2 = cyc; wr_en = 1'b0;
        end
      end
    end
    rd_en = 1'b0; wr_en = 1'b0;
    exp_rd = rd_exp;
    n_vec++;
    if (pulses !== 2) begin
      n_err++; $display("FAIL b2b pulses: got %0d need 2", pulses);
    end
    n_vec++;
    if (lat1 !== exp_lat(RD_N, WC) || lat2 !== exp_lat(RD_N, WC) + 1 + exp_lat(WR_N, WC)) begin
      n_err++;
      $display("FAIL b2b latency: got %0d/%0d need %0d/%0d", lat1, lat2, exp_lat(RD_N, WC),
               exp_lat(RD_N, WC) + 1 + exp_lat(WR_N, WC));
    end
    for (int i = 0; i < WR_N; i++) begin
      e = {18'((base_of(a) + i) % MEM_N), d[i*16 +: 16]};
      n_vec++;
      if (i >= wr_log.size() || wr_log[i] !== e) begin
        n_err++; $display("FAIL b2b write beat%0d: need %h", i, e);
      end
      ref_mem[(base_of(a) + i) % MEM_N] = d[i*16 +: 16];
    end
  endtask

  task automatic test_reset_mid();
    int pulses, lat, oe, we; bit drv;
    logic [31:0] a;
    a = 32'h0000_1000;
    @(negedge clk);
    rd_en = 1'b1; address = a;
    @(posedge clk);
    repeat (5) @(posedge clk);
    #1;
    n_vec++;
    if (sram_addr !== 18'(base_of(a) + 2) || read_data !== exp_rd) begin
      n_err++; $display("FAIL midrst setup: addr %h rd %h need %h/%h", sram_addr, read_data,
                        18'(base_of(a) + 2), exp_rd);
    end
    #1 rst = 1'b1;
    #1;
    n_vec++;
    if (ce_n !== 1'b1 || oe_n !== 1'b1 || dut.dq_oe !== 1'b0 || read_data !== 64'h0 || ready !== 1'b0) begin
      n_err++; $display("FAIL midrst outputs: ce %b oe %b drv %b rd %h rdy %b need 1 1 0 0 0",
                        ce_n, oe_n, dut.dq_oe, read_data, ready);
    end
    @(negedge clk);
    rst = 1'b0; rd_en = 1'b0;
    exp_rd = 64'h0;
    pulses = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (ready) pulses++;
    end
    n_vec++;
    if (pulses !== 0) begin
      n_err++; $display("FAIL midrst ready pulses: got %0d need 0", pulses);
    end
    run_req(1'b1, 1'b0, a, 32'h0, lat, oe, we, drv);
    check_read("midrst_next", a, lat, oe, drv);
  endtask

  task automatic test_narrow();
    int lat, oe;
    logic [31:0] a, e;
    for (int n = 0; n < 3; n++) begin
      a = 32'($urandom_range(0, 4000));
      for (int i = 0; i < 4; i++) begin
        mem8[a + i] = 8'($urandom);
        e[i*8 +: 8] = mem8[a + i];
      end
      @(negedge clk);
      n_rd = 1'b1; n_addr = a;
      @(posedge clk);
      lat = 0; oe = 0;
      while (lat < 30) begin
        @(posedge clk); #1;
        lat++;
        n_addr = $urandom;
        if (!n_oe) oe++;
        if (n_ready) break;
      end
      n_rd = 1'b0;
      n_vec++;
      if (n_read_data !== e) begin
        n_err++; $display("FAIL narrow data: got %h need %h", n_read_data, e);
      end
      n_vec++;
      if (lat !== exp_lat(4, 0) || oe !== 4) begin
        n_err++; $display("FAIL narrow timing: lat %0d oe %0d need %0d/4", lat, oe, exp_lat(4, 0));
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    rd_en = 1'b0; wr_en = 1'b0; address = '0; write_data = '0;
    n_rd = 1'b0; n_wr = 1'b0; n_addr = '0; n_wdata = '0;
    for (int i = 0; i < MEM_N; i++) begin
      mem[i] = '0; ref_mem[i] = '0; mem8[i] = '0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_write_directed();
    test_read_directed();
    test_wrap();
    test_random();
    test_back_to_back();
    test_reset_mid();
    test_narrow();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sram_burst_controller.md
Name: sram_burst_controller

Overview:
Parametrised SRAM controller that sits between the memory pipeline stage and an external asynchronous SRAM.
- Reads a burst of BURST_WORDS CPU words.
- Writes one CPU word, serialised into narrow SRAM beats.
- Inserts programmable wait states per beat and generates all SRAM strobes.
- Pulses ready to release the pipeline stall.

Parameters:
- ADDR_W, 32, CPU byte-address width.
- DATA_W, 32, CPU word width; must be an integer multiple of DQ_W.
- DQ_W, 16, SRAM data bus width (8 or 16).
- SRAM_ADDR_W, 18, SRAM word-address width.
- BURST_WORDS, 2, CPU words returned per read (1..8).
- WAIT_CYCLES, 1, extra cycles per SRAM beat (0..7); each beat lasts WAIT_CYCLES+1 cycles.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- rd_en  in  1  read request; held until ready
- wr_en  in  1  write request; held until ready
- address  in  ADDR_W  CPU byte address
- write_data  in  DATA_W  write word
- read_data  out  BURST_WORDS*DATA_W  burst result; word 0 and beat 0 in the LSBs
- ready  out  1  one-cycle completion pulse
- SRAM_DQ  inout  DQ_W  SRAM data bus
- SRAM_ADDR  out  SRAM_ADDR_W  SRAM word address
- SRAM_WE_N  out  1  write enable, active low
- SRAM_OE_N  out  1  output enable, active low
- SRAM_CE_N  out  1  chip enable, active low

Behaviour:
- Reset: rst asynchronous, active-high; clock clk.
- Reset values:
  - state IDLE, ready 0, read_data 0, SRAM_ADDR 0.
  - SRAM_WE_N, SRAM_OE_N and SRAM_CE_N all 1.
  - SRAM_DQ high-Z.
- Derived constants:
  - BPW = DATA_W/DQ_W (beats per word).
  - RD_BEATS = BURST_WORDS*BPW.
  - WR_BEATS = BPW.
  - base = address >> log2(DQ_W/8), truncated to SRAM_ADDR_W.
- States and transitions:
  - IDLE: on rd_en or wr_en, latch op, base and write_data; clear beat and wait counters; go to ACCESS. If both are asserted, the read wins; the write is serviced after the read, because the request is still held.
  - ACCESS: SRAM_ADDR = base + beat, modulo 2^SRAM_ADDR_W (wraps). The wait counter runs 0..WAIT_CYCLES. On the last cycle of a beat, the beat counter increments. After the last beat, go to DONE.
  - DONE: ready = 1 for exactly this cycle; next state IDLE unconditionally. Requests seen during DONE are not accepted.
- Outputs are registered (state-decoded from registered state); no combinational path from rd_en/wr_en to SRAM pins.
- Read strobes:
  - CE_N = 0 and OE_N = 0 throughout ACCESS; WE_N = 1.
  - SRAM_DQ is sampled on the last cycle of each beat into slice [beat*DQ_W +: DQ_W].
- Write strobes:
  - CE_N = 0 and OE_N = 1.
  - DQ driven with write_data[beat*DQ_W +: DQ_W] for the whole beat.
  - WE_N = 0 on every cycle of the beat except the last (address/data hold). When WAIT_CYCLES = 0, WE_N = 0 for the single cycle.
- Latency: with the request sampled at edge k, ready is high in cycle k+1+N*(WAIT_CYCLES+1), where N = RD_BEATS or WR_BEATS.
  - Defaults: read ready at offset 9, write at offset 5.
- read_data holds its value until the next read completes; writes never alter it.
- address, write_data, rd_en and wr_en changes during ACCESS are ignored; the latched copies are used.
- Reset mid-operation: immediate return to the reset values; DQ released in the same cycle; no ready pulse.
- SRAM_DQ is never driven during a read, in IDLE, or in DONE.

Decomposition:
- Package sram_ctrl_pkg holds:
  - state enum (IDLE, ACCESS, DONE);
  - op enum (OP_RD, OP_WR);
  - functions/constants for BPW, RD_BEATS, WR_BEATS and counter widths (clog2);
  - a parameter-legality check (DATA_W % DQ_W == 0).
- One sub-module, sram_beat_timer, holds the wait and beat counters. Its outputs are beat index, last_cycle_of_beat and last_beat.

Test Plan:
- Write, defaults: address 0x404, data 0xDEADBEEF -> SRAM_ADDR 0x202 with DQ 0xBEEF, then 0x203 with DQ 0xDEAD; WE_N low 1 cycle per beat; ready at offset 5.
- Read, defaults: SRAM model holds 0x202..0x205 = BEEF, DEAD, 1234, 5678; rd_en at 0x404 -> read_data 0x56781234DEADBEEF; ready at offset 9; OE_N low for 8 cycles.
- Wrap: read at address 0x7FFFC -> SRAM_ADDR sequence 0x3FFFE, 0x3FFFF, 0x00000, 0x00001.
- Simultaneous rd_en and wr_en held -> read burst completes first (ready pulse), then the write burst; exactly two ready pulses.
- Reset mid-read at ACCESS beat 2 -> in the same cycle, CE_N/OE_N = 1, DQ high-Z, read_data = 0; no ready pulse; the next read completes normally.
- WAIT_CYCLES = 0, DQ_W = 8 -> one read (BURST_WORDS = 1, DATA_W = 32) takes 4 beats; ready at offset 5; bytes are assembled little-endian.
